// File: rtl/sr_latch_trng.sv
// SR-latch entropy source: XOR-reduced latch race bits, optional von Neumann
// debiasing, repetition-count health test and LSB-first word packing onto valid/ready.

module sr_latch (
  input  logic s_i,
  input  logic r_i,
  output logic q_o
);

  // Behavioural stand-in for the physical latch; the s=r race has no model and simply holds.
  always_latch begin
    if (s_i ^ r_i) q_o <= s_i;
  end

endmodule

module sr_latch_trng #(
  parameter int unsigned NUM_LATCHES = 8,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEBIAS      = 1,
  parameter int unsigned REP_LIMIT   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enabled,
  input  logic                   use_ext,
  input  logic [NUM_LATCHES-1:0] ext_bits,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun,
  output logic                   health_fail
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RUN_W = 8;

  logic [NUM_LATCHES-1:0] latch_q;
  logic                   latch_hold;
  logic                   latch_s;
  logic                   latch_r;

  // Hold (s=0, r=1) in reset or when disabled; otherwise race both inputs on clk.
  assign latch_hold = rst | ~enabled;
  assign latch_s    = latch_hold ? 1'b0 : clk;
  assign latch_r    = latch_hold ? 1'b1 : clk;

  for (genvar i = 0; i < NUM_LATCHES; i++) begin : g_latch
    sr_latch u_latch (
      .s_i (latch_s),
      .r_i (latch_r),
      .q_o (latch_q[i])
    );
  end

  logic raw_bit_q, raw_bit_d;
  logic raw_vld_q;

  assign raw_bit_d = ^(use_ext ? ext_bits : latch_q);

  // Stage 1: one raw bit per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_bit_q <= 1'b0;
      raw_vld_q <= 1'b0;
    end else begin
      raw_vld_q <= enabled;
      if (enabled) raw_bit_q <= raw_bit_d;
    end
  end

  logic [RUN_W-1:0] run_q, run_d;
  logic             prev_q, prev_d;
  logic             seen_q, seen_d;
  logic             half_q, half_d;
  logic             half_vld_q, half_vld_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             health_fail_q, health_fail_d;
  logic             acc_en;
  logic             acc_bit;

  // Stage 2: health test, debias, packing and output handshake.
  always_comb begin
    run_d         = run_q;
    prev_d        = prev_q;
    seen_d        = seen_q;
    half_d        = half_q;
    half_vld_d    = half_vld_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    overrun_d     = overrun_q;
    health_fail_d = health_fail_q;
    acc_en        = 1'b0;
    acc_bit       = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (raw_vld_q) begin
      seen_d = 1'b1;
      prev_d = raw_bit_q;
      if (!seen_q || (raw_bit_q != prev_q)) run_d = RUN_W'(1);
      else if (run_q != RUN_W'(REP_LIMIT))  run_d = run_q + RUN_W'(1);
      if (run_d == RUN_W'(REP_LIMIT)) health_fail_d = 1'b1;

      if (DEBIAS != 0) begin
        if (!half_vld_q) begin
          half_d     = raw_bit_q;
          half_vld_d = 1'b1;
        end else begin
          half_vld_d = 1'b0;
          acc_en     = half_q ^ raw_bit_q;
          acc_bit    = half_q;
        end
      end else begin
        acc_en  = 1'b1;
        acc_bit = raw_bit_q;
      end
    end

    if (acc_en && !health_fail_d) begin
      acc_d[cnt_q] = acc_bit;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        cnt_d = '0;
        if (!out_valid_d) begin
          out_data_d  = acc_d;
          out_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A tripped health test blocks output until reset.
    if (health_fail_d) begin
      out_valid_d = 1'b0;
      cnt_d       = '0;
      half_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q         <= '0;
      prev_q        <= 1'b0;
      seen_q        <= 1'b0;
      half_q        <= 1'b0;
      half_vld_q    <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      run_q         <= run_d;
      prev_q        <= prev_d;
      seen_q        <= seen_d;
      half_q        <= half_d;
      half_vld_q    <= half_vld_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      overrun_q     <= overrun_d;
      health_fail_q <= health_fail_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;
  assign health_fail = health_fail_q;

endmodule

// File: tb/tb_sr_latch_trng.sv
// Bench for sr_latch_trng: two instances (plain WIDTH=8, debiased WIDTH=2) share
// stimulus; a bit-list reference model is compared every cycle alongside directed checks.

module tb_sr_latch_trng;

  localparam int unsigned NL  = 8;
  localparam int unsigned REP = 16;
  localparam int unsigned M_W  [2] = '{8, 2};
  localparam int unsigned M_DB [2] = '{0, 1};
  localparam logic [NL-1:0] T1 [8] = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h03, 8'h03, 8'h01, 8'h03};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enabled = 1'b0;
  logic          use_ext = 1'b1;
  logic          out_ready = 1'b1;
  logic [NL-1:0] ext_bits = '0;
  logic [7:0]    a_data;
  logic          a_valid, a_ovr, a_hf;
  logic [1:0]    b_data;
  logic          b_valid, b_ovr, b_hf;

  always #5 clk = ~clk;

  sr_latch_trng #(.NUM_LATCHES(NL), .WIDTH(8), .DEBIAS(0), .REP_LIMIT(REP)) u_dut_a (
    .clk(clk), .rst(rst), .enabled(enabled), .use_ext(use_ext), .ext_bits(ext_bits),
    .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
    .overrun(a_ovr), .health_fail(a_hf)
  );

  sr_latch_trng #(.NUM_LATCHES(NL), .WIDTH(2), .DEBIAS(1), .REP_LIMIT(REP)) u_dut_b (
    .clk(clk), .rst(rst), .enabled(enabled), .use_ext(use_ext), .ext_bits(ext_bits),
    .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
    .overrun(b_ovr), .health_fail(b_hf)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: raw bit history, pair counting and integer word building.
  bit          m_pv, m_pb;
  bit          hist[$];
  int unsigned m_nraw;
  bit          m_half;
  bit          m_hf;
  int unsigned m_word[2], m_cnt[2], m_data[2];
  bit          m_valid[2], m_ovr[2];

  task automatic model_reset();
    m_pv = 0; m_pb = 0; hist.delete(); m_nraw = 0; m_half = 0; m_hf = 0;
    for (int i = 0; i < 2; i++) begin
      m_word[i] = 0; m_cnt[i] = 0; m_data[i] = 0; m_valid[i] = 0; m_ovr[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit same, acc_en, acc_bit;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) if (m_valid[i] && out_ready) m_valid[i] = 0;
    if (m_pv) begin
      hist.push_back(m_pb);
      if (hist.size() > int'(REP)) void'(hist.pop_front());
      same = (hist.size() == int'(REP));
      for (int k = 0; k < hist.size(); k++) if (hist[k] != m_pb) same = 0;
      if (same) m_hf = 1;
      m_nraw++;
      for (int i = 0; i < 2; i++) begin
        if (M_DB[i] != 0) begin
          acc_en  = (m_nraw % 2 == 0) && (m_half != m_pb);
          acc_bit = m_half;
        end else begin
          acc_en  = 1;
          acc_bit = m_pb;
        end
        if (!m_hf && acc_en) begin
          if (acc_bit) m_word[i] += (32'd1 << m_cnt[i]);
          m_cnt[i]++;
          if (m_cnt[i] == M_W[i]) begin
            if (!m_valid[i]) begin
              m_data[i]  = m_word[i];
              m_valid[i] = 1;
            end else begin
              m_ovr[i] = 1;
            end
            m_word[i] = 0;
            m_cnt[i]  = 0;
          end
        end
      end
      if (m_nraw % 2 == 1) m_half = m_pb;
    end
    if (m_hf) for (int i = 0; i < 2; i++) m_valid[i] = 0;
    m_pv = enabled;
    if (enabled) m_pb = 1'($countones(ext_bits) % 2);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("A.data",   32'(a_data),  m_data[0]);
    check("A.valid",  32'(a_valid), 32'(m_valid[0]));
    check("A.ovr",    32'(a_ovr),   32'(m_ovr[0]));
    check("A.health", 32'(a_hf),    32'(m_hf));
    check("B.data",   32'(b_data),  m_data[1]);
    check("B.valid",  32'(b_valid), 32'(m_valid[1]));
    check("B.ovr",    32'(b_ovr),   32'(m_ovr[1]));
    check("B.health", 32'(b_hf),    32'(m_hf));
  endtask

  task automatic drive(input bit en, input logic [NL-1:0] ext);
    enabled  = en;
    ext_bits = ext;
    step();
  endtask

  task automatic do_reset();
    rst = 1; enabled = 0;
    step();
    rst = 0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst.data",   32'(a_data),  32'h0);
    check("rst.valid",  32'(a_valid), 32'h0);
    check("rst.ovr",    32'(a_ovr),   32'h0);
    check("rst.health", 32'(a_hf),   32'h0);

    // Word assembly, two-cycle latency, one-cycle valid
    out_ready = 1;
    for (int k = 0; k < 8; k++) drive(1, T1[k]);
    check("t1.valid_early", 32'(a_valid), 32'h0);
    drive(0, '0);
    check("t1.data",  32'(a_data),  32'h4D);
    check("t1.valid", 32'(a_valid), 32'h1);
    drive(0, '0);
    check("t1.valid_drop", 32'(a_valid), 32'h0);

    // Debiaser: raw 01,00,10,11
    do_reset();
    begin
      logic [7:0] raw;
      raw = 8'b1101_0010;
      for (int k = 0; k < 8; k++) begin
        drive(1, NL'(raw[k]));
        if (k == 6) begin
          check("t2.valid", 32'(b_valid), 32'h1);
          check("t2.data",  32'(b_data),  32'h2);
        end
      end
    end
    drive(0, '0);
    check("t2.data_end",  32'(b_data),  32'h2);
    check("t2.valid_end", 32'(b_valid), 32'h0);
    check("t2.ovr",       32'(b_ovr),   32'h0);

    // Backpressure and overrun
    do_reset();
    out_ready = 0;
    for (int k = 0; k < 16; k++) drive(1, (k % 2 == 0) ? NL'(1) : NL'(0));
    drive(0, '0);
    check("t3.data",  32'(a_data),  32'h55);
    check("t3.valid", 32'(a_valid), 32'h1);
    check("t3.ovr",   32'(a_ovr),   32'h1);
    out_ready = 1;
    drive(0, '0);
    check("t3.valid_drop", 32'(a_valid), 32'h0);
    check("t3.ovr_sticky", 32'(a_ovr),   32'h1);

    // Health test trips on the 16th identical sample
    do_reset();
    for (int k = 0; k < 16; k++) drive(1, NL'(1));
    check("t4.health_pre", 32'(a_hf), 32'h0);
    for (int k = 0; k < 16; k++) begin
      drive(1, (k % 2 == 0) ? NL'(0) : NL'(1));
      if (k == 0) check("t4.health", 32'(a_hf), 32'h1);
      check("t4.valid_blocked", 32'(a_valid), 32'h0);
    end
    drive(0, '0);
    check("t4.valid_final", 32'(a_valid), 32'h0);
    do_reset();
    check("t4.health_clr", 32'(a_hf),  32'h0);
    check("t4.ovr_clr",    32'(a_ovr), 32'h0);

    // Reset mid-word
    for (int k = 0; k < 5; k++) drive(1, NL'(1));
    do_reset();
    for (int k = 0; k < 8; k++) drive(1, NL'(k % 2));
    drive(0, '0);
    check("t5.data",  32'(a_data),  32'hAA);
    check("t5.valid", 32'(a_valid), 32'h1);

    // Enable gaps every other cycle
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1, T1[k]);
      if (k == 7) check("t6.valid_early", 32'(a_valid), 32'h0);
      drive(0, '0);
    end
    check("t6.data",  32'(a_data),  32'h4D);
    check("t6.valid", 32'(a_valid), 32'h1);

    // Randomised traffic against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(299) == 0);
      enabled   = ($urandom_range(3) != 0);
      ext_bits  = NL'($urandom);
      out_ready = ($urandom_range(2) != 0);
      step();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
